soc_ifc_fw_upd_rst_ctrl: RTL and testbench

Upstream request/sequencing stage for the boot FSM's firmware-update reset path. It converts a software register write into the level `fw_update_rst` request the boot FSM samples in BOOT_DONE, and supplies a lock-protected `fw_update_rst_wait_cycles` value. It tracks the reset through BOOT_FW_RST/BOOT_WAIT back to BOOT_DONE, then reports completion, timeout and a saturating count of executed resets. It sits in soc_ifc on the cptra_rst_b domain, so it survives the uC-only reset it requests.

---
 rtl/soc_ifc_fw_upd_rst_ctrl_if.sv | 46 ++++
 rtl/soc_ifc_fw_upd_rst_ctrl.sv | 148 ++++++++++++++
 tb/tb_soc_ifc_fw_upd_rst_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_ifc_fw_upd_rst_ctrl_if.sv
// Boot FSM state type shared with soc_ifc, plus the request/status bundle
// between firmware-update register logic and the reset sequencing stage.
package soc_ifc_fw_upd_rst_pkg;

   typedef enum logic [2:0] {
      BOOT_IDLE   = 3'd0,
      BOOT_FUSE   = 3'd1,
      BOOT_FW_RST = 3'd2,
      BOOT_WAIT   = 3'd3,
      BOOT_DONE   = 3'd4
   } boot_fsm_state_e;

endpackage

interface soc_ifc_fw_upd_rst_ctrl_if #(
   parameter int CNT_W = 8
);
   import soc_ifc_fw_upd_rst_pkg::*;

   logic             req_we;
   logic             req_wdata;
   logic             wait_we;
   logic [7:0]       wait_wdata;
   boot_fsm_state_e  boot_fsm_ps;
   logic             fw_update_rst_window;
   logic             fw_update_rst;
   logic [7:0]       fw_update_rst_wait_cycles;
   logic             busy;
   logic             done_pulse;
   logic             timeout_err;
   logic             wr_ignored_err;
   logic [CNT_W-1:0] rst_count;

   modport master (
      output req_we, req_wdata, wait_we, wait_wdata, boot_fsm_ps, fw_update_rst_window,
      input  fw_update_rst, fw_update_rst_wait_cycles, busy, done_pulse,
             timeout_err, wr_ignored_err, rst_count
   );

   modport slave (
      input  req_we, req_wdata, wait_we, wait_wdata, boot_fsm_ps, fw_update_rst_window,
      output fw_update_rst, fw_update_rst_wait_cycles, busy, done_pulse,
             timeout_err, wr_ignored_err, rst_count
   );

endinterface

// File: rtl/soc_ifc_fw_upd_rst_ctrl.sv
// Turns a software firmware-update request into the boot FSM's fw_update_rst level,
// follows the reset through BOOT_FW_RST/BOOT_WAIT and reports completion status.
module soc_ifc_fw_upd_rst_ctrl
   import soc_ifc_fw_upd_rst_pkg::*;
#(
   parameter logic [7:0] DEFAULT_WAIT = 8'd10,
   parameter logic [7:0] MIN_WAIT     = 8'd5,
   parameter int         ACK_TIMEOUT  = 1024,
   parameter int         CNT_W        = 8
) (
   input  logic                         clk,
   input  logic                         cptra_rst_b,
   soc_ifc_fw_upd_rst_ctrl_if.slave     ctrl
);

   localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);
   localparam bit TO_EN = (ACK_TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      ACKED   = 2'd2,
      RECOVER = 2'd3
   } state_e;

   state_e           state;
   state_e           state_nxt;
   logic [TO_W-1:0]  to_cnt;
   logic             req_set;
   logic             to_hit;
   logic             done_hit;
   logic             wr_ign;

   logic             fw_update_rst_q;
   logic [7:0]       wait_cycles_q;
   logic             busy_q;
   logic             done_pulse_q;
   logic             timeout_err_q;
   logic             wr_ignored_err_q;
   logic [CNT_W-1:0] rst_count_q;

   // Ack beats cancel beats timeout; warm reset (BOOT_IDLE) silently aborts tracking.
   always_comb begin
      state_nxt = state;
      req_set   = 1'b0;
      to_hit    = 1'b0;
      done_hit  = 1'b0;
      wr_ign    = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl.req_we && ctrl.req_wdata) begin
               state_nxt = REQ;
               req_set   = 1'b1;
            end
         end
         REQ: begin
            if (ctrl.boot_fsm_ps == BOOT_FW_RST) begin
               state_nxt = ACKED;
            end else if (ctrl.req_we && !ctrl.req_wdata) begin
               state_nxt = IDLE;
            end else if (TO_EN && (to_cnt == TO_LAST)) begin
               state_nxt = IDLE;
               to_hit    = 1'b1;
            end
         end
         ACKED: begin
            if (ctrl.boot_fsm_ps == BOOT_WAIT) begin
               state_nxt = RECOVER;
            end else if (ctrl.boot_fsm_ps == BOOT_IDLE) begin
               state_nxt = IDLE;
            end
         end
         RECOVER: begin
            if ((ctrl.boot_fsm_ps == BOOT_DONE) && !ctrl.fw_update_rst_window) begin
               state_nxt = IDLE;
               done_hit  = 1'b1;
            end else if (ctrl.boot_fsm_ps == BOOT_IDLE) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE) begin
         wr_ign = (ctrl.req_we && ctrl.req_wdata) || ctrl.wait_we;
      end
   end

   // State register; the request level is simply "next state is REQ".
   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         state           <= IDLE;
         fw_update_rst_q <= 1'b0;
         busy_q          <= 1'b0;
         done_pulse_q    <= 1'b0;
      end else begin
         state           <= state_nxt;
         fw_update_rst_q <= (state_nxt == REQ);
         busy_q          <= (state_nxt != IDLE);
         done_pulse_q    <= done_hit;
      end
   end

   // Ack timeout counter saturates instead of wrapping; only a new request clears it.
   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         to_cnt <= '0;
      end else if (req_set) begin
         to_cnt <= '0;
      end else if ((state == REQ) && (to_cnt != {TO_W{1'b1}})) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Wait value is writable only in IDLE, so a same-cycle request still captures the new value.
   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         wait_cycles_q    <= DEFAULT_WAIT;
         timeout_err_q    <= 1'b0;
         wr_ignored_err_q <= 1'b0;
         rst_count_q      <= '0;
      end else begin
         if ((state == IDLE) && ctrl.wait_we) begin
            wait_cycles_q <= (ctrl.wait_wdata < MIN_WAIT) ? MIN_WAIT : ctrl.wait_wdata;
         end
         if (req_set) begin
            timeout_err_q <= 1'b0;
         end else if (to_hit) begin
            timeout_err_q <= 1'b1;
         end
         if (wr_ign) begin
            wr_ignored_err_q <= 1'b1;
         end
         if (done_hit && (rst_count_q != {CNT_W{1'b1}})) begin
            rst_count_q <= rst_count_q + 1'b1;
         end
      end
   end

   assign ctrl.fw_update_rst             = fw_update_rst_q;
   assign ctrl.fw_update_rst_wait_cycles = wait_cycles_q;
   assign ctrl.busy                      = busy_q;
   assign ctrl.done_pulse                = done_pulse_q;
   assign ctrl.timeout_err               = timeout_err_q;
   assign ctrl.wr_ignored_err            = wr_ignored_err_q;
   assign ctrl.rst_count                 = rst_count_q;

endmodule

// File: tb/tb_soc_ifc_fw_upd_rst_ctrl.sv
// Randomized scenario bench for the firmware-update reset sequencer, with a
// small scoreboard of expected register values kept alongside the stimulus.
module tb_soc_ifc_fw_upd_rst_ctrl;
   import soc_ifc_fw_upd_rst_pkg::*;

   localparam int CNT_W       = 2;
   localparam int ACK_TIMEOUT = 16;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic cptra_rst_b = 1'b0;

   soc_ifc_fw_upd_rst_ctrl_if #(.CNT_W(CNT_W)) ifc();

   soc_ifc_fw_upd_rst_ctrl #(
      .DEFAULT_WAIT (8'd10),
      .MIN_WAIT     (8'd5),
      .ACK_TIMEOUT  (ACK_TIMEOUT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk         (clk),
      .cptra_rst_b (cptra_rst_b),
      .ctrl        (ifc.slave)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   int         exp_count;
   logic [7:0] exp_wait;
   logic       exp_wr_ign;

   int   fl_fw_hi;
   int   fl_pulses;
   int   fl_wait_min;
   int   fl_wait_max;
   logic fl_busy_at_pulse;
   logic fl_busy_end;

   function automatic logic [7:0] clamp_wait(input logic [7:0] v);
      return (v < 8'd5) ? 8'd5 : v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      ifc.req_we     = 1'b0;
      ifc.req_wdata  = 1'b0;
      ifc.wait_we    = 1'b0;
      ifc.wait_wdata = 8'd0;
   endtask

   task automatic sample_flow();
      if (ifc.fw_update_rst === 1'b1) fl_fw_hi++;
      if (ifc.done_pulse === 1'b1) begin
         fl_pulses++;
         fl_busy_at_pulse = ifc.busy;
      end
      if (int'(ifc.fw_update_rst_wait_cycles) < fl_wait_min) fl_wait_min = int'(ifc.fw_update_rst_wait_cycles);
      if (int'(ifc.fw_update_rst_wait_cycles) > fl_wait_max) fl_wait_max = int'(ifc.fw_update_rst_wait_cycles);
   endtask

   // Boot FSM stand-in: takes the arc d cycles after the request edge, spends w cycles in
   // BOOT_WAIT, then holds the reset window for win_hold cycles inside BOOT_DONE.
   task automatic run_flow(input int d, input int w, input int win_hold);
      fl_fw_hi = 0; fl_pulses = 0; fl_wait_min = 256; fl_wait_max = -1;
      fl_busy_at_pulse = 1'b1;
      ifc.boot_fsm_ps = BOOT_DONE;
      ifc.fw_update_rst_window = 1'b0;
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
      tick();
      quiet_inputs();
      sample_flow();
      for (int i = 0; i < d; i++) begin tick(); sample_flow(); end
      ifc.boot_fsm_ps = BOOT_FW_RST;
      ifc.fw_update_rst_window = 1'b1;
      tick(); sample_flow();
      tick(); sample_flow();
      ifc.boot_fsm_ps = BOOT_WAIT;
      for (int i = 0; i < w; i++) begin tick(); sample_flow(); end
      ifc.boot_fsm_ps = BOOT_DONE;
      for (int i = 0; i < win_hold; i++) begin tick(); sample_flow(); end
      ifc.fw_update_rst_window = 1'b0;
      for (int i = 0; i < 4; i++) begin tick(); sample_flow(); end
      fl_busy_end = ifc.busy;
   endtask

   task automatic check_flow(input int d, input string tag);
      vectors++;
      if (fl_fw_hi != d + 1) begin
         miscompares++;
         $display("[TB] FAIL %s fw_high_cycles: got %0d expected %0d", tag, fl_fw_hi, d + 1);
      end
      vectors++;
      if (fl_pulses != 1 || fl_busy_at_pulse !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s done_pulse: got %0d pulses busy=%0b expected 1 pulse busy=0", tag, fl_pulses, fl_busy_at_pulse);
      end
      vectors++;
      if (fl_wait_min != int'(exp_wait) || fl_wait_max != int'(exp_wait)) begin
         miscompares++;
         $display("[TB] FAIL %s wait_cycles: got %0d..%0d expected %0d", tag, fl_wait_min, fl_wait_max, exp_wait);
      end
      vectors++;
      if (ifc.rst_count !== exp_count[CNT_W-1:0] || fl_busy_end !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s rst_count/busy: got %0d/%0b expected %0d/0", tag, ifc.rst_count, fl_busy_end, exp_count);
      end
   endtask

   task automatic model_reset();
      exp_count  = 0;
      exp_wait   = 8'd10;
      exp_wr_ign = 1'b0;
   endtask

   task automatic test_reset();
      quiet_inputs();
      ifc.boot_fsm_ps = BOOT_DONE;
      ifc.fw_update_rst_window = 1'b0;
      cptra_rst_b = 1'b0;
      model_reset();
      tick(); tick();
      cptra_rst_b = 1'b1;
      tick();
      vectors++;
      if ({ifc.fw_update_rst, ifc.busy, ifc.done_pulse, ifc.timeout_err, ifc.wr_ignored_err} !== 5'b0 ||
          ifc.rst_count !== '0 || ifc.fw_update_rst_wait_cycles !== 8'd10) begin
         miscompares++;
         $display("[TB] FAIL reset_values: got fw=%0b busy=%0b done=%0b to=%0b ign=%0b cnt=%0d wait=%0d expected zeros, wait=10",
                  ifc.fw_update_rst, ifc.busy, ifc.done_pulse, ifc.timeout_err, ifc.wr_ignored_err,
                  ifc.rst_count, ifc.fw_update_rst_wait_cycles);
      end
   endtask

   task automatic test_clamp();
      logic [7:0] vals [4] = '{8'd2, 8'd4, 8'd5, 8'd6};
      logic [7:0] v;
      for (int i = 0; i < 10; i++) begin
         v = (i < 4) ? vals[i] : 8'($urandom_range(0, 255));
         ifc.wait_we = 1'b1; ifc.wait_wdata = v;
         tick();
         quiet_inputs();
         exp_wait = clamp_wait(v);
         vectors++;
         if (ifc.fw_update_rst_wait_cycles !== exp_wait || ifc.wr_ignored_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clamp wdata=%0d: got %0d ign=%0b expected %0d ign=0", v, ifc.fw_update_rst_wait_cycles, ifc.wr_ignored_err, exp_wait);
         end
      end
   endtask

   task automatic test_nominal();
      int d, w, h;
      ifc.wait_we = 1'b1; ifc.wait_wdata = 8'd20;
      tick();
      quiet_inputs();
      exp_wait = 8'd20;
      run_flow(2, 20, 0);
      exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
      check_flow(2, "nominal");
      d = $urandom_range(0, 5); w = $urandom_range(1, 8); h = $urandom_range(0, 3);
      run_flow(d, w, h);
      exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
      check_flow(d, "nominal_rand");
   endtask

   task automatic test_lock();
      ifc.wait_we = 1'b1; ifc.wait_wdata = 8'd2;
      tick();
      quiet_inputs();
      exp_wait = clamp_wait(8'd2);
      ifc.boot_fsm_ps = BOOT_DONE;
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
      tick();
      quiet_inputs();
      ifc.boot_fsm_ps = BOOT_FW_RST;
      ifc.fw_update_rst_window = 1'b1;
      tick();
      ifc.wait_we = 1'b1; ifc.wait_wdata = 8'd50;
      tick();
      quiet_inputs();
      exp_wr_ign = 1'b1;
      vectors++;
      if (ifc.fw_update_rst_wait_cycles !== exp_wait || ifc.wr_ignored_err !== exp_wr_ign || ifc.busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lock: got wait=%0d ign=%0b busy=%0b expected wait=%0d ign=1 busy=1",
                  ifc.fw_update_rst_wait_cycles, ifc.wr_ignored_err, ifc.busy, exp_wait);
      end
      ifc.boot_fsm_ps = BOOT_WAIT;
      tick();
      ifc.boot_fsm_ps = BOOT_DONE;
      ifc.fw_update_rst_window = 1'b0;
      tick();
      exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
      vectors++;
      if (ifc.done_pulse !== 1'b1 || ifc.rst_count !== exp_count[CNT_W-1:0]) begin
         miscompares++;
         $display("[TB] FAIL lock_done: got pulse=%0b cnt=%0d expected 1/%0d", ifc.done_pulse, ifc.rst_count, exp_count);
      end
      tick();
   endtask

   task automatic test_timeout();
      int hi, pulses;
      hi = 0; pulses = 0;
      ifc.boot_fsm_ps = BOOT_FUSE;
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
      tick();
      quiet_inputs();
      for (int i = 0; i < ACK_TIMEOUT + 20; i++) begin
         if (ifc.fw_update_rst === 1'b1) hi++;
         if (ifc.done_pulse === 1'b1) pulses++;
         if (i == 3) begin ifc.req_we = 1'b1; ifc.req_wdata = 1'b1; end
         if (i == 4) quiet_inputs();
         tick();
      end
      vectors++;
      if (hi != ACK_TIMEOUT) begin
         miscompares++;
         $display("[TB] FAIL timeout_len: got %0d expected %0d", hi, ACK_TIMEOUT);
      end
      vectors++;
      if (ifc.timeout_err !== 1'b1 || ifc.busy !== 1'b0 || pulses != 0 || ifc.rst_count !== exp_count[CNT_W-1:0]) begin
         miscompares++;
         $display("[TB] FAIL timeout_state: got to=%0b busy=%0b pulses=%0d cnt=%0d expected 1/0/0/%0d",
                  ifc.timeout_err, ifc.busy, pulses, ifc.rst_count, exp_count);
      end
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
      tick();
      quiet_inputs();
      vectors++;
      if (ifc.timeout_err !== 1'b0 || ifc.fw_update_rst !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL timeout_clear: got to=%0b fw=%0b expected 0/1", ifc.timeout_err, ifc.fw_update_rst);
      end
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b0;
      tick();
      quiet_inputs();
      ifc.boot_fsm_ps = BOOT_DONE;
   endtask

   task automatic test_cancel();
      int c;
      for (int k = 0; k < 3; k++) begin
         c = (k == 0) ? 3 : $urandom_range(1, 10);
         ifc.boot_fsm_ps = BOOT_DONE;
         ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
         tick();
         quiet_inputs();
         for (int i = 1; i < c; i++) tick();
         vectors++;
         if (ifc.fw_update_rst !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cancel_pre c=%0d: got fw=%0b expected 1", c, ifc.fw_update_rst);
         end
         ifc.req_we = 1'b1; ifc.req_wdata = 1'b0;
         tick();
         quiet_inputs();
         vectors++;
         if (ifc.fw_update_rst !== 1'b0 || ifc.busy !== 1'b0 || ifc.done_pulse !== 1'b0 ||
             ifc.rst_count !== exp_count[CNT_W-1:0]) begin
            miscompares++;
            $display("[TB] FAIL cancel c=%0d: got fw=%0b busy=%0b done=%0b cnt=%0d expected 0/0/0/%0d",
                     c, ifc.fw_update_rst, ifc.busy, ifc.done_pulse, ifc.rst_count, exp_count);
         end
      end
   endtask

   task automatic test_cancel_vs_ack();
      ifc.boot_fsm_ps = BOOT_DONE;
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
      tick();
      quiet_inputs();
      tick();
      ifc.boot_fsm_ps = BOOT_FW_RST;
      ifc.fw_update_rst_window = 1'b1;
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b0;
      tick();
      quiet_inputs();
      vectors++;
      if (ifc.busy !== 1'b1 || ifc.fw_update_rst !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL cancel_vs_ack: got busy=%0b fw=%0b expected 1/0", ifc.busy, ifc.fw_update_rst);
      end
      ifc.boot_fsm_ps = BOOT_WAIT;
      tick();
      ifc.boot_fsm_ps = BOOT_DONE;
      ifc.fw_update_rst_window = 1'b0;
      tick();
      exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
      vectors++;
      if (ifc.done_pulse !== 1'b1 || ifc.rst_count !== exp_count[CNT_W-1:0]) begin
         miscompares++;
         $display("[TB] FAIL cancel_vs_ack_done: got pulse=%0b cnt=%0d expected 1/%0d", ifc.done_pulse, ifc.rst_count, exp_count);
      end
      tick();
   endtask

   task automatic test_warm_abort();
      int pulses;
      for (int k = 0; k < 2; k++) begin
         pulses = 0;
         ifc.boot_fsm_ps = BOOT_DONE;
         ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
         tick();
         quiet_inputs();
         ifc.boot_fsm_ps = BOOT_FW_RST;
         ifc.fw_update_rst_window = 1'b1;
         tick();
         if (k == 0) begin
            ifc.boot_fsm_ps = BOOT_WAIT;
            tick(); tick();
         end
         ifc.boot_fsm_ps = BOOT_IDLE;
         ifc.fw_update_rst_window = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            if (ifc.done_pulse === 1'b1) pulses++;
         end
         vectors++;
         if (ifc.busy !== 1'b0 || pulses != 0 || ifc.rst_count !== exp_count[CNT_W-1:0]) begin
            miscompares++;
            $display("[TB] FAIL warm_abort k=%0d: got busy=%0b pulses=%0d cnt=%0d expected 0/0/%0d",
                     k, ifc.busy, pulses, ifc.rst_count, exp_count);
         end
         ifc.boot_fsm_ps = BOOT_DONE;
         tick();
      end
   endtask

   task automatic test_wait_with_req();
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      ifc.boot_fsm_ps = BOOT_FUSE;
      ifc.wait_we = 1'b1; ifc.wait_wdata = v;
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
      tick();
      quiet_inputs();
      exp_wait = clamp_wait(v);
      vectors++;
      if (ifc.fw_update_rst_wait_cycles !== exp_wait || ifc.busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wait_with_req v=%0d: got wait=%0d busy=%0b expected %0d/1", v, ifc.fw_update_rst_wait_cycles, ifc.busy, exp_wait);
      end
      ifc.wait_we = 1'b1; ifc.wait_wdata = ~v;
      tick();
      quiet_inputs();
      vectors++;
      if (ifc.fw_update_rst_wait_cycles !== exp_wait) begin
         miscompares++;
         $display("[TB] FAIL wait_locked_in_req: got %0d expected %0d", ifc.fw_update_rst_wait_cycles, exp_wait);
      end
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b0;
      tick();
      quiet_inputs();
      ifc.boot_fsm_ps = BOOT_DONE;
   endtask

   task automatic test_async_reset();
      ifc.boot_fsm_ps = BOOT_FUSE;
      ifc.req_we = 1'b1; ifc.req_wdata = 1'b1;
      tick();
      quiet_inputs();
      tick();
      cptra_rst_b = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({ifc.fw_update_rst, ifc.busy, ifc.done_pulse, ifc.timeout_err, ifc.wr_ignored_err} !== 5'b0 ||
          ifc.rst_count !== '0 || ifc.fw_update_rst_wait_cycles !== exp_wait) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got fw=%0b busy=%0b done=%0b to=%0b ign=%0b cnt=%0d wait=%0d expected zeros, wait=%0d",
                  ifc.fw_update_rst, ifc.busy, ifc.done_pulse, ifc.timeout_err, ifc.wr_ignored_err,
                  ifc.rst_count, ifc.fw_update_rst_wait_cycles, exp_wait);
      end
      tick();
      cptra_rst_b = 1'b1;
      ifc.boot_fsm_ps = BOOT_DONE;
      tick();
      vectors++;
      if (ifc.busy !== 1'b0 || ifc.fw_update_rst !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset_release: got busy=%0b fw=%0b expected 0/0", ifc.busy, ifc.fw_update_rst);
      end
   endtask

   task automatic test_saturation();
      int d, w, h;
      for (int k = 0; k < 5; k++) begin
         d = $urandom_range(0, 4); w = $urandom_range(1, 6); h = $urandom_range(0, 2);
         run_flow(d, w, h);
         exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
         vectors++;
         if (ifc.rst_count !== exp_count[CNT_W-1:0] || fl_pulses != 1) begin
            miscompares++;
            $display("[TB] FAIL saturation k=%0d: got cnt=%0d pulses=%0d expected %0d/1", k, ifc.rst_count, fl_pulses, exp_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clamp();
      test_nominal();
      test_lock();
      test_timeout();
      test_cancel();
      test_cancel_vs_ack();
      test_warm_abort();
      test_wait_with_req();
      test_async_reset();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
